mpu_det_sequencer: RTL

//  Multi-cycle determinant controller for the MPU. It accepts one packed 5x5 int8 matrix and a size (1..5) over a

---
 rtl/mpu_pkg.sv | 10 +
 rtl/mpu_det3_core.sv | 18 +
 rtl/mpu_det_sequencer.sv | 107 ++++++++++
 3 files changed

// File: rtl/mpu_pkg.sv
// mpu_pkg: shared widths, packed-matrix indexing and FSM encoding for the MPU determinant sequencer
package mpu_pkg;
  localparam int EW = 8;
  localparam int DIM = 5;
  localparam int MAT_W = DIM * DIM * EW;
  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;
  function automatic logic [7:0] at(input logic [2:0] r, input logic [2:0] c);
    return {5'd0, r} * 8'd40 + {5'd0, c} * 8'd8;
  endfunction
endpackage

// File: rtl/mpu_det3_core.sv
// mpu_det3_core: combinational 3x3 determinant, result wrapped to EW bits
//   m   in  9*EW  row-major elements, element k at [k*EW +: EW]
//   det out EW    determinant modulo 2^EW
// Low EW bits of sums/products are identical for signed and unsigned operands,
// so plain EW-bit arithmetic gives the exact wrapped signed result.
module mpu_det3_core
  import mpu_pkg::*;
(
  input  logic [9*EW-1:0] m,
  output logic [EW-1:0]   det
);
  logic [EW-1:0] e [9];
  always_comb
    for (int k = 0; k < 9; k++) e[k] = m[k*EW +: EW];
  assign det = e[0] * (e[4] * e[8] - e[5] * e[7])
             - e[1] * (e[3] * e[8] - e[5] * e[6])
             + e[2] * (e[3] * e[7] - e[4] * e[6]);
endmodule

// File: rtl/mpu_det_sequencer.sv
// mpu_det_sequencer: multi-cycle 1..5 determinant by Laplace expansion, one minor term per clock
//   clock/reset_n                 clock, async active-low reset
//   in_valid/in_ready/in_matrix/in_size   request handshake (accepted only in IDLE)
//   out_valid/out_ready/out_det/out_err   result handshake, held until consumed
//   busy                          high while evaluating terms
module mpu_det_sequencer
  import mpu_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:MAT_W-1] in_matrix,
  input  logic [7:0]       in_size,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EW-1:0]    out_det,
  output logic             out_err,
  output logic             busy
);
  state_t state_q, state_d;
  logic [0:MAT_W-1] mat_q, mat_d;
  logic signed [7:0] size_q, size_d;
  logic [2:0] i_q, i_d;
  logic [1:0] j_q, j_d;
  logic [EW-1:0] acc_q, acc_d;
  logic valid_sz, neg, last;
  logic [2:0] sz, base, cj, lo, hi;
  logic [2:0] col [3];
  logic [9*EW-1:0] cells;
  logic [EW-1:0] det, coef, prod, term;
  function automatic logic [2:0] skip(input logic [2:0] k, input logic [2:0] s);
    return k + {2'b0, k >= s};
  endfunction
  assign valid_sz = size_q > 8'sd0 && size_q < 8'sd6;
  assign sz = size_q[2:0];
  assign base = sz == 3'd5 ? 3'd2 : sz == 3'd4 ? 3'd1 : 3'd0;
  // j-th surviving column of row 1 once column i is removed
  assign cj = {1'b0, j_q} + {2'b0, {1'b0, j_q} >= i_q};
  assign lo = i_q < cj ? i_q : cj;
  assign hi = i_q < cj ? cj : i_q;
  // Sizes 1 and 2 are padded with identity so the same 3x3 core yields a00 and a00*a11-a01*a10
  always_comb begin
    cells = '0;
    for (int k = 0; k < 3; k++) begin
      col[k] = sz == 3'd5 ? skip(skip(3'(k), lo), hi) : sz == 3'd4 ? skip(3'(k), i_q) : 3'(k);
    end
    for (int k = 0; k < 3; k++)
      for (int m = 0; m < 3; m++)
        cells[(k*3+m)*EW +: EW] = (sz < 3'd3 && (3'(k) >= sz || 3'(m) >= sz)) ?
                                  (k == m ? 8'd1 : 8'd0) : mat_q[at(base + 3'(k), col[m]) +: EW];
  end
  mpu_det3_core u_det3 (.m(cells), .det(det));
  assign coef = sz == 3'd5 ? mat_q[at(3'd0, i_q) +: EW] * mat_q[at(3'd1, cj) +: EW] :
                sz == 3'd4 ? mat_q[at(3'd0, i_q) +: EW] : 8'd1;
  assign prod = coef * det;
  assign neg = sz == 3'd5 ? i_q[0] ^ j_q[0] : sz == 3'd4 ? i_q[0] : 1'b0;
  assign term = neg ? 8'd0 - prod : prod;
  assign last = (!valid_sz || sz < 3'd4) ? 1'b1 : sz == 3'd4 ? i_q == 3'd3 : (i_q == 3'd4 && j_q == 2'd3);
  always_comb begin
    state_d = state_q;
    mat_d = mat_q;
    size_d = size_q;
    i_d = i_q;
    j_d = j_q;
    acc_d = acc_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = EVAL;
        mat_d = in_matrix;
        size_d = in_size;
        i_d = '0;
        j_d = '0;
        acc_d = '0;
      end
      EVAL: begin
        if (valid_sz) acc_d = acc_q + term;
        j_d = sz == 3'd5 ? j_q + 2'd1 : j_q;
        i_d = (sz != 3'd5 || j_q == 2'd3) ? i_q + 3'd1 : i_q;
        state_d = last ? DONE : EVAL;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      mat_q <= '0;
      size_q <= '0;
      i_q <= '0;
      j_q <= '0;
      acc_q <= '0;
    end else begin
      state_q <= state_d;
      mat_q <= mat_d;
      size_q <= size_d;
      i_q <= i_d;
      j_q <= j_d;
      acc_q <= acc_d;
    end
  assign in_ready = state_q == IDLE;
  assign busy = state_q == EVAL;
  assign out_valid = state_q == DONE;
  assign out_det = out_valid ? acc_q : '0;
  assign out_err = out_valid && !valid_sz;
endmodule
